msk_g4mul_hpc3_feeder: RTL
==========================

Name: msk_g4mul_hpc3_feeder

Overview:
- Upstream feeder and downstream capture stage around the team's HPC3 masked GF(4) multiplier gadget (MSKg4mul_hpc3, latency 1). The gadget is instantiated inside this block.
- Accepts one shared operand pair per transaction with a valid/ready handshake and pulls fresh randomness from a valid/ready stream.
- Generates the gadget's one-cycle-delayed copy of operand a, and gates gadget inputs to zero outside the firing window.
- Registers the shared product and presents it with valid/ready.

Parameters:
d, 2, number of shares per bit (masking order d-1).
RND_W, 2*d*(d-1), randomness bits consumed per multiplication (equals the gadget rnd width).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand pair available.
in_ready  output  1  block accepts operands.
in_a0, in_a1  input  d each  shared bit0 and bit1 of operand a.
in_b0, in_b1  input  d each  shared bit0 and bit1 of operand b.
rnd_in  input  RND_W  fresh randomness.
rnd_valid  input  1  rnd_in valid.
rnd_ready  output  1  randomness consumed this cycle.
out_valid  output  1  product shares valid.
out_ready  input  1  downstream accepts product.
out0, out1  output  d each  shared bit0 and bit1 of the product.
busy  output  1  high in every state other than IDLE.
op_count  output  16  completed output handshakes; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n low at an edge, from any state, including mid-operation):
  - state goes to IDLE.
  - Operand registers, a_prev register, out0, out1 and op_count are cleared to 0.
  - out_valid=0, rnd_ready=0, busy=0, in_ready=1 in the first cycle after reset.
  - An in-flight operation is discarded silently.
- State machine (4 states):
  - IDLE: in_ready=1. If in_valid, capture in_a*/in_b* into operand registers and go to LOAD.
  - LOAD: rnd_ready=1. fire = rnd_valid. If fire, go to MUL; otherwise stay in LOAD with operands held.
  - MUL: single cycle. Capture gadget out0/out1 into output registers, clear the operand registers, go to OUT.
  - OUT: out_valid=1 with out0/out1 stable. If out_ready, increment op_count and go to IDLE. Otherwise hold.
- Gadget input gating (leakage hygiene):
  - Gadget ina/inb are driven from the operand registers only when state==LOAD and fire=1; otherwise they are driven to 0.
  - Gadget rnd = rnd_in when fire, otherwise 0.
  - Gadget ina_prev is driven from a register that samples the gadget ina input every cycle (reset 0). In MUL it therefore equals exactly the a shares applied at fire.
- Latency: handshake accepted in cycle c0, fire in c1 (when rnd_valid is already high), out_valid high in c3. Each rnd_valid-low cycle in LOAD adds one cycle.
- Throughput: at most one operation per 4 cycles. in_ready=0 in LOAD, MUL and OUT.
- Randomness:
  - Exactly one rnd handshake per operation.
  - rnd_ready is never high outside LOAD.
  - rnd_in is ignored unless fire.
- Simultaneous events:
  - in_valid during OUT is not accepted; it must be re-presented in IDLE.
  - out_ready and reset at the same edge: reset wins and op_count is not incremented.
- Correctness: the unmasked product {^out1, ^out0} equals G4_mul({^a1,^a0}, {^b1,^b0}) of the team's GF(4) model, for any randomness.
- Output shares only change at the MUL→OUT edge or on reset.

Test Plan:
- d=2, reset held 2 cycles, then released -> out_valid=0, in_ready=1, op_count=0, gadget ina/inb/rnd all 0.
- Accept a=0 (shares 2'b11/2'b11), b=3, rnd_valid always 1, out_ready=1 -> rnd_ready pulses once in c1, out_valid in c3 only, unmasked product 0, op_count=1.
- Exhaustive sweep of 16 (a,b) pairs with random share splits and random rnd_in -> every unmasked product matches the G4_mul model. Share values vary across runs with equal unmasked results.
- rnd_valid held low 5 cycles in LOAD -> gadget ina/inb stay 0, state stays LOAD, out_valid first high 8 cycles after the accept edge.
- out_ready low 3 cycles in OUT -> out0/out1 and out_valid stable, in_ready=0, op_count increments only on the handshake cycle.
- rst_n asserted in MUL -> next cycle IDLE, out_valid=0, op_count unchanged-to-0 (cleared), a_prev register 0. Preset op_count to 0xFFFF via 65535 ops, then one more op -> op_count=0.

Source files
------------

// File: rtl/msk_g4mul_hpc3_feeder.sv
// -----------------------------------------------------------------------------
// msk_g4mul_hpc3_feeder
//   Feeder and capture stage around the HPC3 masked GF(4) multiplier gadget
//   (MSKg4mul_hpc3, latency 1). Operand shares are taken in with a valid/ready
//   handshake. The gadget fires once a randomness beat is available. The shared
//   product is registered and offered downstream with valid/ready.
//
//   GF(4) elements are {bit1, bit0} in polynomial basis modulo x^2 + x + 1.
//
// Ports
//   clk                clock, all state on rising edge
//   rst_n              synchronous active-low reset
//   in_valid/in_ready  operand handshake
//   in_a0/in_a1        shares of bit0/bit1 of operand a (d bits each)
//   in_b0/in_b1        shares of bit0/bit1 of operand b (d bits each)
//   rnd_in             fresh randomness (RND_W bits)
//   rnd_valid/ready    randomness handshake (one beat per multiplication)
//   out_valid/ready    product handshake
//   out0/out1          shares of bit0/bit1 of the product
//   busy               high whenever not IDLE
//   op_count           completed output handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------
module msk_g4mul_hpc3_feeder #(
  parameter int d     = 2,
  parameter int RND_W = 2*d*(d-1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [d-1:0]     in_a0,
  input  logic [d-1:0]     in_a1,
  input  logic [d-1:0]     in_b0,
  input  logic [d-1:0]     in_b1,
  input  logic [RND_W-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [d-1:0]     out0,
  output logic [d-1:0]     out1,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} state_t;

  state_t           state_reg, state_next;
  logic [d-1:0]     a0_reg, a1_reg, b0_reg, b1_reg;
  logic [d-1:0]     aprev0_reg, aprev1_reg;
  logic [d-1:0]     out0_reg, out1_reg;
  logic [15:0]      op_count_reg;

  logic             fire;
  logic             capture_in, capture_out, count_en;
  logic [d-1:0]     gad_ina0, gad_ina1, gad_inb0, gad_inb1;
  logic [RND_W-1:0] gad_rnd;
  logic [d-1:0]     gad_out0, gad_out1;

  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    rnd_ready   = 1'b0;
    out_valid   = 1'b0;
    fire        = 1'b0;
    capture_in  = 1'b0;
    capture_out = 1'b0;
    count_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture_in = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        rnd_ready = 1'b1;
        fire      = rnd_valid;
        if (rnd_valid) state_next = MUL;
      end
      MUL: begin
        capture_out = 1'b1;
        state_next  = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          count_en   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shares reach the gadget only in the firing cycle; at all other times
  // the gadget sees zeros so that idle operands do not toggle its logic.
  assign gad_ina0 = {d{fire}} & a0_reg;
  assign gad_ina1 = {d{fire}} & a1_reg;
  assign gad_inb0 = {d{fire}} & b0_reg;
  assign gad_inb1 = {d{fire}} & b1_reg;
  assign gad_rnd  = {RND_W{fire}} & rnd_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      a0_reg       <= '0;
      a1_reg       <= '0;
      b0_reg       <= '0;
      b1_reg       <= '0;
      aprev0_reg   <= '0;
      aprev1_reg   <= '0;
      out0_reg     <= '0;
      out1_reg     <= '0;
      op_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      // Delayed copy of the gadget a input; in MUL it holds the fired shares.
      aprev0_reg <= gad_ina0;
      aprev1_reg <= gad_ina1;
      if (capture_in) begin
        a0_reg <= in_a0;
        a1_reg <= in_a1;
        b0_reg <= in_b0;
        b1_reg <= in_b1;
      end
      if (capture_out) begin
        out0_reg <= gad_out0;
        out1_reg <= gad_out1;
        a0_reg   <= '0;
        a1_reg   <= '0;
        b0_reg   <= '0;
        b1_reg   <= '0;
      end
      if (count_en) op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign out0     = out0_reg;
  assign out1     = out1_reg;
  assign op_count = op_count_reg;
  assign busy     = (state_reg != IDLE);

  MSKg4mul_hpc3 #(.d(d), .RND_W(RND_W)) u_gadget (
    .clk       (clk),
    .ina0      (gad_ina0),
    .ina1      (gad_ina1),
    .inb0      (gad_inb0),
    .inb1      (gad_inb1),
    .ina0_prev (aprev0_reg),
    .ina1_prev (aprev1_reg),
    .rnd       (gad_rnd),
    .out0      (gad_out0),
    .out1      (gad_out1)
  );

endmodule

// -----------------------------------------------------------------------------
// MSKg4mul_hpc3
//   HPC3-style masked GF(4) multiplier, latency 1. Each share is a GF(4)
//   element {in*1[i], in*0[i]}. For every share pair i<j one 4-bit slice of
//   rnd supplies r (bits [1:0]) and r' (bits [3:2]).
//     z_i = a'_i*Reg(b_i) ^ sum_{j!=i} ( Reg(a_i*(b_j^r_ij) ^ r'_ij) ^ a'_i*Reg(r_ij) )
//   where a'_i is ina*_prev, the a shares presented one cycle later. The r
//   terms cancel inside each cross product and r' cancels across shares.
// Ports
//   clk              clock
//   ina0/ina1        a shares (bit0/bit1), inb0/inb1 b shares
//   ina0_prev/1_prev a shares delayed by one cycle
//   rnd              fresh randomness, RND_W bits
//   out0/out1        product shares, valid one cycle after inputs
// -----------------------------------------------------------------------------
module MSKg4mul_hpc3 #(
  parameter int d     = 2,
  parameter int RND_W = 2*d*(d-1)
) (
  input  logic             clk,
  input  logic [d-1:0]     ina0,
  input  logic [d-1:0]     ina1,
  input  logic [d-1:0]     inb0,
  input  logic [d-1:0]     inb1,
  input  logic [d-1:0]     ina0_prev,
  input  logic [d-1:0]     ina1_prev,
  input  logic [RND_W-1:0] rnd,
  output logic [d-1:0]     out0,
  output logic [d-1:0]     out1
);

  localparam int NP = d*(d-1)/2;

  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    gf4_mul = {(x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]),
               (x[0] & y[0]) ^ (x[1] & y[1])};
  endfunction

  // Index of unordered share pair {i,j} among the NP pairs.
  function automatic int pidx(input int i, input int j);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    pidx = lo*d - (lo*(lo+1))/2 + (hi - lo - 1);
  endfunction

  logic [1:0] a_sh [d];
  logic [1:0] ap_sh[d];
  logic [1:0] b_sh [d];
  logic [1:0] b_reg[d];
  logic [1:0] r_reg[NP];
  logic [1:0] cross_reg[d][d];
  logic [1:0] z[d];

  generate
    for (genvar gi = 0; gi < d; gi++) begin : g_share
      assign a_sh[gi]  = {ina1[gi], ina0[gi]};
      assign ap_sh[gi] = {ina1_prev[gi], ina0_prev[gi]};
      assign b_sh[gi]  = {inb1[gi], inb0[gi]};
      assign out0[gi]  = z[gi][0];
      assign out1[gi]  = z[gi][1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < d; i++) begin
      b_reg[i] <= b_sh[i];
      for (int j = 0; j < d; j++) begin
        if (i == j) cross_reg[i][j] <= '0;
        else cross_reg[i][j] <= gf4_mul(a_sh[i], b_sh[j] ^ rnd[4*pidx(i, j) +: 2])
                                ^ rnd[4*pidx(i, j) + 2 +: 2];
      end
    end
    for (int p = 0; p < NP; p++) r_reg[p] <= rnd[4*p +: 2];
  end

  always_comb begin
    for (int i = 0; i < d; i++) begin
      z[i] = gf4_mul(ap_sh[i], b_reg[i]);
      for (int j = 0; j < d; j++) begin
        z[i] = z[i] ^ cross_reg[i][j];
        if (i != j) z[i] = z[i] ^ gf4_mul(ap_sh[i], r_reg[pidx(i, j)]);
      end
    end
  end

endmodule
